// File: rtl/controlador_injecao.sv
// Hamming(15,11) error-injection campaign controller: drives a codeword and
//    bit index to an external injector, hands each vector to a decoder and
//    scores the decoder's corrected output against the original codeword.
// Latency: inicio to first dec_valido 1 cycle; each test takes 1 cycle in
//    ENVIA plus the decoder response time (max 64 cycles); FIM lasts 1 cycle.
// Backpressure: dec_valido holds, with inj_n/inj_erro stable, until dec_pronto
//    is sampled high; a missing decoder result times out after 64 cycles.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   inicio, modo, posicao      start request, 0=sweep/1=single shot, shot position
//   palavra                    codeword under test (latched with inicio)
//   inj_entrada, inj_n,        codeword, bit index and enable for the injector
//   inj_erro
//   dec_valido, dec_pronto     vector handshake toward the decoder
//   res_valido, res_dados      decoder result
//   ocupado, concluido         campaign running, one-cycle completion pulse
//   acertos, falhas, estouro   pass count, fail count, sticky timeout flag

module controlador_injecao (
   input  logic        clk,
   input  logic        rst,
   input  logic        inicio,
   input  logic        modo,
   input  logic [3:0]  posicao,
   input  logic [14:0] palavra,
   output logic [14:0] inj_entrada,
   output logic [3:0]  inj_n,
   output logic        inj_erro,
   output logic        dec_valido,
   input  logic        dec_pronto,
   input  logic        res_valido,
   input  logic [14:0] res_dados,
   output logic        ocupado,
   output logic        concluido,
   output logic [4:0]  acertos,
   output logic [4:0]  falhas,
   output logic        estouro
);

   typedef enum logic [1:0] {OCIOSO, ENVIA, ESPERA, FIM} estado_t;

   estado_t     r_estado;
   estado_t     w_prox;

   logic [14:0] r_palavra;
   logic        r_modo;
   logic [3:0]  r_posicao;
   logic [3:0]  r_k;
   logic [5:0]  r_tempo;
   logic [4:0]  r_acertos;
   logic [4:0]  r_falhas;
   logic        r_estouro;

   logic        w_ultimo;
   logic        w_expira;
   logic        w_fim_teste;
   logic [3:0]  w_n;
   logic        w_erro;

   // Single shot always ends after its only test; sweep ends after k=15.
   assign w_ultimo    = r_modo | (r_k == 4'd15);
   // 64th consecutive ESPERA edge without a result.
   assign w_expira    = (r_tempo == 6'd63);
   assign w_fim_teste = res_valido | w_expira;

   // Sweep: k=0 is the clean reference word, k>=1 flips bit k-1.
   assign w_erro = r_modo | (r_k != 4'd0);
   assign w_n    = r_modo ? r_posicao : ((r_k == 4'd0) ? 4'd0 : r_k - 4'd1);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_estado <= OCIOSO;
      end else begin
         r_estado <= w_prox;
      end
   end

   always_comb begin
      w_prox      = r_estado;
      inj_entrada = 15'd0;
      inj_n       = 4'd0;
      inj_erro    = 1'b0;
      dec_valido  = 1'b0;
      ocupado     = 1'b0;
      concluido   = 1'b0;
      case (r_estado)
         OCIOSO: begin
            if (inicio) w_prox = ENVIA;
         end
         ENVIA: begin
            ocupado     = 1'b1;
            dec_valido  = 1'b1;
            inj_entrada = r_palavra;
            inj_n       = w_n;
            inj_erro    = w_erro;
            if (dec_pronto) w_prox = ESPERA;
         end
         ESPERA: begin
            ocupado     = 1'b1;
            inj_entrada = r_palavra;
            inj_n       = w_n;
            inj_erro    = w_erro;
            if (w_fim_teste) w_prox = w_ultimo ? FIM : ENVIA;
         end
         FIM: begin
            ocupado     = 1'b1;
            concluido   = 1'b1;
            inj_entrada = r_palavra;
            w_prox      = OCIOSO;
         end
         default: w_prox = OCIOSO;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_palavra <= 15'd0;
         r_modo    <= 1'b0;
         r_posicao <= 4'd0;
         r_k       <= 4'd0;
         r_tempo   <= 6'd0;
         r_acertos <= 5'd0;
         r_falhas  <= 5'd0;
         r_estouro <= 1'b0;
      end else begin
         case (r_estado)
            OCIOSO: begin
               if (inicio) begin
                  r_palavra <= palavra;
                  r_modo    <= modo;
                  r_posicao <= posicao;
                  r_k       <= 4'd0;
                  r_acertos <= 5'd0;
                  r_falhas  <= 5'd0;
                  r_estouro <= 1'b0;
               end
            end
            ENVIA: begin
               if (dec_pronto) r_tempo <= 6'd0;
            end
            ESPERA: begin
               // A result on the expiry edge wins over the timeout.
               if (res_valido) begin
                  if (res_dados == r_palavra) r_acertos <= r_acertos + 5'd1;
                  else                        r_falhas  <= r_falhas + 5'd1;
               end else if (w_expira) begin
                  r_falhas  <= r_falhas + 5'd1;
                  r_estouro <= 1'b1;
               end else begin
                  r_tempo <= r_tempo + 6'd1;
               end
               if (w_fim_teste && !w_ultimo) r_k <= r_k + 4'd1;
            end
            default: ;
         endcase
      end
   end

   assign acertos = r_acertos;
   assign falhas  = r_falhas;
   assign estouro = r_estouro;

endmodule

// File: tb/tb_controlador_injecao.sv
// Testbench for controlador_injecao: scoreboard of expected handshakes and
//    campaign results, with a behavioural decoder (configurable latency,
//    backpressure, single-position fault, spurious result pulses).

module tb_controlador_injecao;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        inicio = 1'b0;
   logic        modo = 1'b0;
   logic [3:0]  posicao = 4'd0;
   logic [14:0] palavra = 15'd0;
   logic [14:0] inj_entrada;
   logic [3:0]  inj_n;
   logic        inj_erro;
   logic        dec_valido;
   logic        dec_pronto = 1'b1;
   logic        res_valido = 1'b0;
   logic [14:0] res_dados = 15'd0;
   logic        ocupado;
   logic        concluido;
   logic [4:0]  acertos;
   logic [4:0]  falhas;
   logic        estouro;

   controlador_injecao dut (
      .clk(clk), .rst(rst), .inicio(inicio), .modo(modo), .posicao(posicao),
      .palavra(palavra), .inj_entrada(inj_entrada), .inj_n(inj_n),
      .inj_erro(inj_erro), .dec_valido(dec_valido), .dec_pronto(dec_pronto),
      .res_valido(res_valido), .res_dados(res_dados), .ocupado(ocupado),
      .concluido(concluido), .acertos(acertos), .falhas(falhas), .estouro(estouro)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_ok  = 0;

   task automatic verifica(input string tag, input logic [63:0] obs, input logic [63:0] esp);
      n_chk++;
      if (obs === esp) n_ok++;
      else $display("FAIL %s: observed %0h, required %0h", tag, obs, esp);
   endtask

   // Scoreboard: {inj_erro, inj_n} per expected handshake, {estouro, falhas, acertos} per campaign.
   logic [4:0]  q_hs[$];
   logic [10:0] q_res[$];
   logic [14:0] cur_pal = 15'd0;

   // Decoder model configuration (written by the main sequence only).
   int lat    = 2;   // result edge = acceptance edge + lat; 0 = never
   int atraso = 0;   // cycles dec_pronto stays low at each ENVIA
   int bad_n  = -1;  // injected position answered with a wrong word
   int spur_pedidos = 0;

   // Monitor-owned state.
   bit         acc_flag = 1'b0;
   logic [3:0] acc_n = 4'd0;
   logic       acc_erro = 1'b0;
   int         hs_cnt = 0;
   int         conc_cnt = 0;
   int         stall_obs = 0;

   // Decoder-owned state.
   int          cd = 0;
   int          stall = 0;
   int          spur_feitos = 0;
   logic [14:0] resp = 15'd0;

   always @(negedge clk) begin
      acc_flag = 1'b0;
      if (dec_valido) begin
         if (q_hs.size() == 0) begin
            verifica("hs_extra", dec_valido, 0);
         end else begin
            verifica("inj_n", inj_n, q_hs[0][3:0]);
            verifica("inj_erro", inj_erro, q_hs[0][4]);
            verifica("inj_entrada", inj_entrada, cur_pal);
            if (dec_pronto) begin
               acc_flag = 1'b1;
               acc_n    = inj_n;
               acc_erro = inj_erro;
               void'(q_hs.pop_front());
               hs_cnt++;
            end else begin
               stall_obs++;
            end
         end
      end
      if (concluido) begin
         conc_cnt++;
         if (q_res.size() == 0) begin
            verifica("concluido_extra", concluido, 0);
         end else begin
            verifica("acertos", acertos, q_res[0][4:0]);
            verifica("falhas", falhas, q_res[0][9:5]);
            verifica("estouro", estouro, q_res[0][10]);
            void'(q_res.pop_front());
         end
      end
   end

   always @(posedge clk) begin
      #1;
      res_valido = 1'b0;
      if (cd > 0) begin
         cd--;
         if (cd == 0) begin
            res_valido = 1'b1;
            res_dados  = resp;
         end
      end
      if (acc_flag) begin
         resp  = (acc_erro && int'(acc_n) == bad_n) ? (cur_pal ^ 15'h0001) : cur_pal;
         stall = 0;
         if (lat == 1) begin
            res_valido = 1'b1;
            res_dados  = resp;
         end else if (lat > 1) begin
            cd = lat - 1;
         end
      end
      if (spur_pedidos != spur_feitos) begin
         res_valido = 1'b1;
         res_dados  = ~cur_pal;
         spur_feitos++;
      end
      if (dec_valido && stall < atraso) begin
         dec_pronto = 1'b0;
         stall++;
      end else begin
         dec_pronto = 1'b1;
      end
   end

   task automatic ciclo();
      @(posedge clk);
      #1;
   endtask

   // Called at posedge+1; drives inicio for one edge and registers expectations.
   task automatic inicia(input logic [14:0] p, input logic m, input logic [3:0] pos,
                         input int ea, input int ef, input logic ee, input bit aborta);
      logic [3:0] nn;
      cur_pal = p;
      if (m) begin
         q_hs.push_back({1'b1, pos});
      end else begin
         for (int k = 0; k < 16; k++) begin
            if (!aborta || k < 7) begin
               nn = (k == 0) ? 4'd0 : 4'(k - 1);
               q_hs.push_back({(k != 0), nn});
            end
         end
      end
      if (!aborta) q_res.push_back({ee, 5'(ef), 5'(ea)});
      palavra = p;
      modo    = m;
      posicao = pos;
      inicio  = 1'b1;
      ciclo();
      inicio  = 1'b0;
      palavra = ~p;
      posicao = ~pos;
      verifica("ocupado_apos_inicio", ocupado, 1);
   endtask

   task automatic aguarda_fim();
      int base = conc_cnt;
      int guarda = 0;
      while (conc_cnt == base && guarda < 2000) begin
         ciclo();
         guarda++;
      end
      verifica("concluido_pulsos", conc_cnt - base, 1);
      verifica("concluido_um_ciclo", {ocupado, concluido}, 2'b00);
      verifica("hs_faltando", q_hs.size(), 0);
      repeat (3) ciclo();
      verifica("pulso_unico", conc_cnt - base, 1);
   endtask

   initial begin
      int base;
      int guarda;
      int s0;
      repeat (3) ciclo();
      verifica("reset_saidas",
               {inj_entrada, inj_n, inj_erro, dec_valido, ocupado, concluido, acertos, falhas, estouro}, 0);

      // Sweep, ideal decoder; inicio on the first edge after reset release.
      rst = 1'b0;
      inicia(15'h2A5C, 1'b0, 4'd0, 16, 0, 1'b0, 1'b0);
      aguarda_fim();

      // Sweep with decoder fault at inj_n=7.
      bad_n = 7;
      inicia(15'h1234, 1'b0, 4'd0, 15, 1, 1'b0, 1'b0);
      aguarda_fim();
      bad_n = -1;

      // Spurious result in OCIOSO: counters hold.
      spur_pedidos++;
      repeat (4) ciclo();
      verifica("hold_ocioso", {ocupado, estouro, falhas, acertos}, {1'b0, 1'b0, 5'd1, 5'd15});

      // Single shot with 5 cycles of backpressure and a spurious result in ENVIA.
      atraso = 5;
      s0 = stall_obs;
      inicia(15'h0F0F, 1'b1, 4'd3, 1, 0, 1'b0, 1'b0);
      spur_pedidos++;
      aguarda_fim();
      atraso = 0;
      verifica("ciclos_backpressure", stall_obs - s0, 5);

      // Single shot at position 15.
      inicia(15'h7FFF, 1'b1, 4'd15, 1, 0, 1'b0, 1'b0);
      aguarda_fim();

      // Timeout: decoder never answers.
      lat = 0;
      inicia(15'h5555, 1'b1, 4'd9, 0, 1, 1'b1, 1'b0);
      aguarda_fim();
      verifica("estouro_retido", estouro, 1);

      // Result exactly on the expiry edge counts as valid.
      lat = 64;
      inicia(15'h3C3C, 1'b1, 4'd2, 1, 0, 1'b0, 1'b0);
      aguarda_fim();

      // inicio pulsed in ESPERA is ignored.
      lat = 10;
      inicia(15'h6B6B, 1'b1, 4'd5, 1, 0, 1'b0, 1'b0);
      repeat (3) ciclo();
      verifica("em_espera", {ocupado, dec_valido}, 2'b10);
      palavra = 15'h0001;
      modo    = 1'b0;
      inicio  = 1'b1;
      ciclo();
      inicio  = 1'b0;
      aguarda_fim();
      lat = 2;

      // Reset during test k=6 of a sweep, then a fresh sweep from k=0.
      base = hs_cnt;
      inicia(15'h2A5C, 1'b0, 4'd0, 0, 0, 1'b0, 1'b1);
      guarda = 0;
      while (hs_cnt < base + 7 && guarda < 500) begin
         ciclo();
         guarda++;
      end
      verifica("hs_antes_reset", hs_cnt - base, 7);
      rst = 1'b1;
      ciclo();
      rst = 1'b0;
      verifica("reset_meio",
               {inj_entrada, inj_n, inj_erro, dec_valido, ocupado, concluido, acertos, falhas, estouro}, 0);
      repeat (5) ciclo();
      verifica("ocioso_pos_reset", {ocupado, dec_valido}, 2'b00);
      inicia(15'h4D2B, 1'b0, 4'd0, 16, 0, 1'b0, 1'b0);
      aguarda_fim();

      $display("%0d/%0d checks passed", n_ok, n_chk);
      $finish;
   end

endmodule
